seq_normalizer: RTL and testbench
=================================

Name: seq_normalizer

Overview:
- Iterative, handshaked normalizer. It is the inverse companion of the datapath shifter.
- Accepts a data word and shifts it left one bit per cycle until MSB=1.
- Returns the normalized word plus the shift amount (leading-zero count). Feeding that amount back into the shifter in the opposite direction reconstructs the input.
- Sits between a producer and consumer, both using valid/ready.

Parameters:
- WIDTH, 8, data width. Power of two, ≥2.
- SHW, $clog2(WIDTH), width of shift-count output. Derived; do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block can accept. Equals (state==IDLE).
- in_data  in  WIDTH  word to normalize.
- in_dir  in  1  only with NORM_DIR_EN. 0=left/leading zeros, 1=right/trailing zeros.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  normalized word.
- out_shift  out  SHW  number of bit positions shifted.
- out_zero  out  1  input was all zeros.

Behaviour:
- Reset (async, immediate, any state):
  - state=IDLE, data_q=0, cnt=0, zero_q=0.
  - out_valid=0, in_ready=1, out_data=0, out_shift=0, out_zero=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: accept on in_valid&&in_ready (cycle N). Latch data_q=in_data, cnt=0.
  - in_data==0: zero_q=1, go DONE.
  - MSB=1: go DONE.
  - Otherwise: go SHIFT.
- SHIFT, each cycle:
  - data_q<=data_q<<1 (zero fill), cnt<=cnt+1.
  - If data_q[WIDTH-2]==1 (the bit becoming MSB), go DONE; else stay.
- DONE: out_valid=1; out_data=data_q, out_shift=cnt, out_zero=zero_q.
  - On out_ready, go IDLE and clear zero_q.
- Latency: out_valid is first high in cycle N+1+lz (lz=leading zeros). Range is 1..WIDTH.
- Zero input: latency 1, out_data=0, out_shift=0, out_zero=1.
- Backpressure: while out_valid&&!out_ready, all outputs are held stable. in_ready stays 0.
- Throughput: one word per lz+2 cycles at best. No accept during SHIFT or DONE.
- in_data and in_valid are ignored outside IDLE. No input buffering.
- cnt never exceeds WIDTH-1, so it fits SHW bits with no wrap.
- Reset asserted mid-SHIFT or mid-DONE discards the transaction. No output pulse follows.

Optional Feature:
- Macro: NORM_DIR_EN.
- Defined:
  - in_dir port exists and is latched at accept.
  - dir=1 shifts right (zero fill into MSB) until LSB=1.
  - Termination test uses data_q[1]; initial test uses in_data[0].
  - out_shift = trailing-zero count. Same latency rule using tz.
- Undefined: port absent, left normalization only; RTL identical to dir=0 behaviour.

Decomposition:
- Package norm_pkg holds:
  - state enum norm_state_e {IDLE, SHIFT, DONE};
  - DEF_WIDTH=8;
  - function clog2-based SHW helper.
- No sub-module. The single-step shift/compare is inline in the FSM.

Test Plan:
- in_data=8'b00010110 accepted at cycle N → out_valid at N+4, out_data=8'b10110000, out_shift=3, out_zero=0.
- in_data=8'b10000000 → out_valid at N+1, out_data unchanged, out_shift=0.
- in_data=8'b00000001 → out_valid at N+8, out_data=8'b10000000, out_shift=7.
- in_data=8'h00 → out_valid at N+1, out_zero=1, out_data=0, out_shift=0.
- 8'b00101000 with out_ready=0 for 3 cycles after out_valid:
  - outputs held at 8'b10100000/shift 2 and in_ready=0 throughout;
  - a new in_valid presented meanwhile is not accepted.
- rst pulsed during SHIFT (input 8'b00000011, cycle N+2) → same-cycle IDLE with out_valid=0, in_ready=1, and no stale result after reset.
  - With NORM_DIR_EN: in_data=8'b11010110, in_dir=1 → out_data=8'b01101011, out_shift=1 at N+2.

Source files
------------

// File: rtl/norm_pkg.sv
// Shared types and constants for the sequential normalizer.
package norm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } norm_state_e;

    localparam int DEF_WIDTH = 8;

    // Shift-count width; a one-bit floor keeps the port legal for tiny widths.
    function automatic int calc_shw(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/seq_normalizer.sv
// Iterative normalizer: shifts one bit per cycle until the leading bit is set.
// Define NORM_DIR_EN to add in_dir and trailing-zero (right) normalization.
module seq_normalizer
    import norm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    localparam int SHW = calc_shw(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
`ifdef NORM_DIR_EN
    input  logic             in_dir,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SHW-1:0]   out_shift,
    output logic             out_zero
);

    norm_state_e      state, state_d;
    logic [WIDTH-1:0] data_q, data_d, shifted;
    logic [SHW-1:0]   cnt, cnt_d;
    logic             zero_q, zero_d;
    logic             init_hit, step_hit;

`ifdef NORM_DIR_EN
    logic dir_q, dir_d;

    // Direction is frozen at accept so a transaction never changes course.
    assign init_hit = in_dir ? in_data[0] : in_data[WIDTH-1];
    assign step_hit = dir_q ? data_q[1] : data_q[WIDTH-2];
    assign shifted  = dir_q ? (data_q >> 1) : (data_q << 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) dir_q <= 1'b0;
        else     dir_q <= dir_d;
    end

    always_comb begin
        dir_d = dir_q;
        if (state == IDLE && in_valid) dir_d = in_dir;
    end
`else
    assign init_hit = in_data[WIDTH-1];
    assign step_hit = data_q[WIDTH-2];
    assign shifted  = data_q << 1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            data_q <= '0;
            cnt    <= '0;
            zero_q <= 1'b0;
        end else begin
            state  <= state_d;
            data_q <= data_d;
            cnt    <= cnt_d;
            zero_q <= zero_d;
        end
    end

    // Termination looks at the bit about to become the leading bit, so DONE
    // is entered on the same edge that completes the final shift.
    always_comb begin
        state_d = state;
        data_d  = data_q;
        cnt_d   = cnt;
        zero_d  = zero_q;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    data_d = in_data;
                    cnt_d  = '0;
                    if (in_data == '0) begin
                        zero_d  = 1'b1;
                        state_d = DONE;
                    end else if (init_hit) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                data_d = shifted;
                cnt_d  = cnt + SHW'(1);
                if (step_hit) state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    zero_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = data_q;
    assign out_shift = cnt;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_seq_normalizer.sv
// Scoreboard bench for seq_normalizer: driver queues expectations, monitor checks results.
module tb_seq_normalizer;
    import norm_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_dir = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_ready, out_valid, out_zero;
    logic [7:0] out_data;
    logic [2:0] out_shift;

    typedef struct {
        logic [7:0] data;
        logic [2:0] shift;
        logic       zero;
        int         lat;
        int         acc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    seq_normalizer #(.WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
`ifdef NORM_DIR_EN
        .in_dir(in_dir),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_shift(out_shift),
        .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Caller is positioned just after a rising edge; returns one cycle after accept.
    task automatic applyStimulus(input logic [7:0] d, input logic dir, input logic [7:0] ed,
                                 input logic [2:0] es, input logic ez, input int lat);
        exp_t e;
        int   guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #2;
            guard++;
        end
        checkOutput("in_ready_wait", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_dir   = dir;
        e.data = ed; e.shift = es; e.zero = ez; e.lat = lat; e.acc = cyc;
        exp_q.push_back(e);
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int guard = 0;
        while ((exp_q.size() != 0 || !in_ready) && guard < 100) begin
            @(posedge clk); #2;
            guard++;
        end
        checkOutput("drain", exp_q.size(), 32'd0);
    endtask

    // Monitor: pops on first valid, then insists the result is held until taken.
    initial begin
        bit   seen = 1'b0;
        exp_t cur;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0;
            end else if (out_valid) begin
                if (!seen) begin
                    checkOutput("result_expected", {31'b0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) begin
                        cur = exp_q.pop_front();
                        seen = 1'b1;
                        checkOutput("latency", cyc - cur.acc, cur.lat);
                    end
                end
                if (seen) begin
                    checkOutput("out_data", {24'b0, out_data}, {24'b0, cur.data});
                    checkOutput("out_shift", {29'b0, out_shift}, {29'b0, cur.shift});
                    checkOutput("out_zero", {31'b0, out_zero}, {31'b0, cur.zero});
                end
                checkOutput("in_ready_busy", {31'b0, in_ready}, 32'd0);
                if (out_ready) seen = 1'b0;
            end else if (seen) begin
                checkOutput("valid_held", {31'b0, out_valid}, 32'd1);
                seen = 1'b0;
            end
        end
    end

    initial begin
        int guard;
        #1;
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("rst_out_data", {24'b0, out_data}, 32'd0);
        checkOutput("rst_out_shift", {29'b0, out_shift}, 32'd0);
        checkOutput("rst_out_zero", {31'b0, out_zero}, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk); #2;

        applyStimulus(8'b00010110, 1'b0, 8'b10110000, 3'd3, 1'b0, 4);
        applyStimulus(8'b10000000, 1'b0, 8'b10000000, 3'd0, 1'b0, 1);
        applyStimulus(8'b00000001, 1'b0, 8'b10000000, 3'd7, 1'b0, 8);
        applyStimulus(8'h00,       1'b0, 8'h00,       3'd0, 1'b1, 1);
        applyStimulus(8'b01111111, 1'b0, 8'b11111110, 3'd1, 1'b0, 2);
        waitDrain();

        // Backpressure: hold the consumer off and offer a word that must be ignored.
        out_ready = 1'b0;
        applyStimulus(8'b00101000, 1'b0, 8'b10100000, 3'd2, 1'b0, 3);
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(posedge clk); #2;
            guard++;
        end
        checkOutput("bp_valid_seen", {31'b0, out_valid}, 32'd1);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        repeat (3) begin
            @(posedge clk); #2;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        waitDrain();
        repeat (4) begin
            @(posedge clk); #2;
        end

        // Reset in the middle of a long shift discards the word.
        applyStimulus(8'b00000011, 1'b0, 8'b11000000, 3'd6, 1'b0, 7);
        @(posedge clk); #2;
        checkOutput("mid_shift_busy", {31'b0, in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_mid_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("rst_mid_shift", {29'b0, out_shift}, 32'd0);
        exp_q.delete();
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk); #2;
        end
        checkOutput("post_rst_idle", {31'b0, in_ready}, 32'd1);

`ifdef NORM_DIR_EN
        applyStimulus(8'b11010110, 1'b1, 8'b01101011, 3'd1, 1'b0, 2);
        applyStimulus(8'b00000100, 1'b0, 8'b10000000, 3'd5, 1'b0, 6);
`endif
        applyStimulus(8'b00100000, 1'b0, 8'b10000000, 3'd2, 1'b0, 3);
        waitDrain();
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
